quad_encoder_gen: RTL and testbench

- Quadrature pulse generator: the transmit side of the encoder A/B interface.
- Accepts move commands (edge count, direction, edge period) over a valid/ready handshake and drives quadA/quadB with correct phase order.
- Maintains a mirror position counter that wraps at counts-per-revolution.
- Used as an encoder emulator for closed-loop bench tests of the quadrature decoder/velocity path, and as a step source for downstream drivers.

---
 rtl/quad_encoder_gen.sv | 190 +++++++++++++++++++
 tb/tb_quad_encoder_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
`timescale 1ns/1ps
// Purpose  : quadrature A/B pulse generator with a wrapping mirror position counter.
// Latency  : first edge period_eff cycles after the accept cycle, then one edge every period_eff cycles.
// Backpr.  : cmd_ready only in IDLE with abort low; commands offered while busy are dropped, not queued.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready move command handshake; cmd_steps edges, cmd_dir (1=fwd), cmd_period cycles/edge
//   abort               synchronous stop of the current move (also blocks acceptance in IDLE)
//   quadA, quadB        registered quadrature outputs
//   busy, done          busy in RUN; done is a one-cycle pulse on normal completion
//   position, remaining mirror count 0..CPR-1 and edges left in the current move
//   index               Z output; only generated when QUAD_INDEX_EN is defined, otherwise tied to 0
//
// Build option: define QUAD_INDEX_EN to generate the registered index output.
module quad_encoder_gen #(
    parameter int CPR        = 1497,
    parameter int PERIOD_W   = 16,
    parameter int STEPS_W    = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                quadA,
    output logic                quadB,
    output logic                busy,
    output logic                done,
    output logic [15:0]         position,
    output logic [STEPS_W-1:0]  remaining,
    output logic                index
);

    localparam logic [15:0]         POS_MAX   = 16'(CPR - 1);
    localparam logic [PERIOD_W-1:0] PER_MIN   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);
    localparam logic [STEPS_W-1:0]  STEPS_ONE = STEPS_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                dir_q, dir_d;
    logic                done_q, done_d;
    logic [15:0]         pos_q, pos_d;
    logic [STEPS_W-1:0]  rem_q, rem_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;

    logic                accept;
    logic [PERIOD_W-1:0] per_eff;
    logic                a_step, b_step;
    logic [15:0]         pos_step;

    assign cmd_ready = (state_q == S_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign per_eff   = (cmd_period < PER_MIN) ? PER_MIN : cmd_period;

    // Next A/B level and position for one edge in the latched direction.
    // Forward walks 00->10->11->01, reverse walks the same ring backwards,
    // so only one channel changes per edge in either direction.
    always_comb begin
        a_step   = a_q;
        b_step   = b_q;
        pos_step = pos_q;
        if (dir_q) begin
            a_step   = ~b_q;
            b_step   = a_q;
            pos_step = (pos_q == POS_MAX) ? 16'd0 : pos_q + 16'd1;
        end else begin
            a_step   = b_q;
            b_step   = ~a_q;
            pos_step = (pos_q == 16'd0) ? POS_MAX : pos_q - 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        pos_d   = pos_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        per_d   = per_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_steps;
                    per_d = per_eff;
                    // Loaded with period-1 so the edge lands exactly
                    // period_eff clocks after the accept edge.
                    cnt_d = per_eff - PER_ONE;
                    if (cmd_steps != '0) begin
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Abort wins over a due edge; everything else freezes.
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    a_d   = a_step;
                    b_d   = b_step;
                    pos_d = pos_step;
                    rem_d = rem_q - STEPS_ONE;
                    cnt_d = per_q - PER_ONE;
                    if (rem_q == STEPS_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PER_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= 16'd0;
            rem_q   <= '0;
            cnt_q   <= '0;
            per_q   <= PER_MIN;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
        end
    end

    assign quadA     = a_q;
    assign quadB     = b_q;
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign position  = pos_q;
    assign remaining = rem_q;

`ifdef QUAD_INDEX_EN
    // Computed from next-state values so index lines up with the
    // position/phase it describes; reset state is pos 0, phase 00.
    logic index_q, index_d;

    always_comb begin
        index_d = (pos_d == 16'd0) && !a_d && !b_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q <= 1'b1;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;
`else
    assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
`timescale 1ns/1ps
module tb_quad_encoder_gen;

    localparam int CPR        = 1497;
    localparam int MIN_PERIOD = 2;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [15:0] cmd_period;
    logic        abort;
    logic        quadA;
    logic        quadB;
    logic        busy;
    logic        done;
    logic [15:0] position;
    logic [15:0] remaining;
    logic        index;

    quad_encoder_gen #(
        .CPR        (CPR),
        .PERIOD_W   (16),
        .STEPS_W    (16),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .quadA      (quadA),
        .quadB      (quadB),
        .busy       (busy),
        .done       (done),
        .position   (position),
        .remaining  (remaining),
        .index      (index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase as an index into the forward ring, position as
    // a plain integer reduced modulo CPR.
    logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int m_ph  = 0;
    int m_pos = 0;

    function automatic int mod_n(input int x, input int n);
        return ((x % n) + n) % n;
    endfunction

    function automatic logic exp_index(input int p, input int ph);
`ifdef QUAD_INDEX_EN
        return (p == 0) && (ph == 0);
`else
        return 1'b0 && (p == ph);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Packed view: {A,B,position,remaining,busy,done,cmd_ready,index}
    function automatic logic [37:0] dut_vec();
        return {quadA, quadB, position, remaining, busy, done, cmd_ready, index};
    endfunction

    task automatic do_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_steps = '0;
        cmd_dir   = 1'b0;
        cmd_period= '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ph  = 0;
        m_pos = 0;
        @(negedge clk);
        check("reset_state", 64'(dut_vec()),
              64'({2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, exp_index(0, 0)}));
    endtask

    // Issue one move at the current negedge and check every cycle until it
    // ends. m = clock edges since the accept edge. ab_m >= 0 raises abort
    // for one cycle at negedge m (seen by the DUT at edge m+1).
    task automatic do_move(input int id, input int steps, input int dir, input int period,
                           input int ab_m, input bit junk);
        int pe, total, last, edges, sgn, ph, p, rem, junk_lim;
        bit aborted, eb, ed, er, ab_now;
        logic [37:0] ev;
        pe    = (period < MIN_PERIOD) ? MIN_PERIOD : period;
        total = steps * pe;
        last  = (ab_m >= 0) ? ab_m + 2 : total;
        junk_lim = (ab_m >= 0) ? ab_m : total - 1;
        sgn   = dir ? 1 : -1;
        edges = 0;
        check($sformatf("ready_before_%0d", id), 64'(cmd_ready), 64'(1));
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_dir    = dir[0];
        cmd_period = 16'(period);
        for (int m = 0; m <= last; m++) begin
            @(negedge clk);
            aborted = (ab_m >= 0) && (m > ab_m);
            edges   = (aborted ? ab_m : m) / pe;
            if (edges > steps) edges = steps;
            eb      = (steps != 0) && !aborted && (edges < steps);
            ed      = !aborted && (m == total);
            ab_now  = (ab_m >= 0) && (m == ab_m + 1);
            er      = !eb && !ab_now;
            ph      = mod_n(m_ph + sgn * edges, 4);
            p       = mod_n(m_pos + sgn * edges, CPR);
            rem     = steps - edges;
            ev      = {ph_tab[ph], 16'(p), 16'(rem), eb, ed, er, exp_index(p, ph)};
            check($sformatf("move%0d_m%0d", id, m), 64'(dut_vec()), 64'(ev));
            abort = (ab_m >= 0) && (m == ab_m);
            if (junk && m < junk_lim) begin
                cmd_valid  = 1'b1;
                cmd_steps  = 16'($urandom_range(0, 500));
                cmd_dir    = 1'($urandom_range(0, 1));
                cmd_period = 16'($urandom_range(0, 9));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        m_ph  = mod_n(m_ph + sgn * edges, 4);
        m_pos = mod_n(m_pos + sgn * edges, CPR);
    endtask

    typedef struct {
        bit         rst_first;
        int         steps;
        int         dir;
        int         period;
        int         ab_m;
        logic [1:0] exp_ab;
        int         exp_pos;
        int         exp_rem;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int total, ab_m, steps, period;
        rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_steps = '0; cmd_dir = 1'b0; cmd_period = '0;

        vecs[0] = '{1'b1,    2, 0, 5, -1, 2'b11, 1495,  0}; // reverse with wrap
        vecs[1] = '{1'b1,    4, 1, 3, -1, 2'b00,    4,  0}; // forward, no wrap
        vecs[2] = '{1'b0,    2, 0, 5, -1, 2'b11,    2,  0}; // direction reversal
        vecs[3] = '{1'b0,    3, 1, 0, -1, 2'b10,    5,  0}; // period clamp
        vecs[4] = '{1'b0,    0, 0, 7, -1, 2'b10,    5,  0}; // zero-length move
        vecs[5] = '{1'b0,  100, 1, 4, 40, 2'b01,   15, 90}; // abort after 10th edge
        vecs[6] = '{1'b0,    5, 0, 3,  8, 2'b10,   13,  3}; // abort on a due edge
        vecs[7] = '{1'b0,    1, 0, 2, -1, 2'b00,   12,  0}; // single edge
        vecs[8] = '{1'b1, 1497, 1, 2, -1, 2'b10,    0,  0}; // full revolution

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst_first) do_reset();
            do_move(i, vecs[i].steps, vecs[i].dir, vecs[i].period, vecs[i].ab_m, 1'b0);
            check($sformatf("vec%0d_ab", i),  64'({quadA, quadB}), 64'(vecs[i].exp_ab));
            check($sformatf("vec%0d_pos", i), 64'(position),       64'(vecs[i].exp_pos));
            check($sformatf("vec%0d_rem", i), 64'(remaining),      64'(vecs[i].exp_rem));
        end

        // Abort held in IDLE: offered command must not be accepted.
        abort      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd5;
        cmd_dir    = 1'b1;
        cmd_period = 16'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("idle_abort_%0d", k), 64'(dut_vec()),
                  64'({ph_tab[m_ph], 16'(m_pos), 16'd0, 1'b0, 1'b0, 1'b0, exp_index(m_pos, m_ph)}));
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        check("idle_abort_release", 64'({cmd_ready, busy, quadA, quadB, position}),
              64'({1'b1, 1'b0, ph_tab[m_ph], 16'(m_pos)}));

        // Back-to-back and randomized moves against the model.
        for (int r = 0; r < 40; r++) begin
            steps  = $urandom_range(0, 12);
            period = $urandom_range(0, 6);
            total  = steps * ((period < MIN_PERIOD) ? MIN_PERIOD : period);
            ab_m   = -1;
            if (total > 0 && $urandom_range(0, 3) == 0) ab_m = $urandom_range(0, total - 1);
            do_move(100 + r, steps, $urandom_range(0, 1), period, ab_m, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a move.
        cmd_valid  = 1'b1;
        cmd_steps  = 16'd50;
        cmd_dir    = 1'b1;
        cmd_period = 16'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        #2 rst = 1'b0;
        #0.5;
        check("async_reset", 64'(dut_vec()),
              64'({2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, exp_index(0, 0)}));
        #0.5 rst = 1'b1;
        m_ph  = 0;
        m_pos = 0;
        @(negedge clk);
        do_move(200, 3, 1, 2, -1, 1'b0);
        check("post_reset_pos", 64'(position), 64'(3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
